// File: rtl/axi_interconnect_v2.sv
// axi_interconnect_v2: AXI4-Lite control slave for the ternary fabric.
// Holds the job config registers, start/busy/done control, per-lane result
// readback and the write-only SRAM bank windows. One write and one read may
// be outstanding at a time; AW and W are buffered independently.
// Optional feature macro: AXI_INTERCONNECT_IRQ_EN (adds irq port and IRQ_EN at 0x20).
module axi_interconnect_v2 #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_LANES       = 15,
    parameter int NUM_SRAM_BANKS  = 2,
    parameter int SRAM_ADDR_WIDTH = 10,
    parameter int SRAM_DATA_WIDTH = 24
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]       s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [DATA_WIDTH-1:0]       s_axi_wdata,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]       s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [DATA_WIDTH-1:0]       s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [ADDR_WIDTH-1:0]       fabric_base_addr,
    output logic [15:0]                 fabric_depth,
    output logic [7:0]                  fabric_stride,
    output logic [31:0]                 fabric_exec_hints,
    output logic [15:0]                 fabric_lane_count,
    output logic                        fabric_start,
    input  logic                        fabric_done,
    input  logic [NUM_LANES*32-1:0]     vector_results,
    output logic [SRAM_ADDR_WIDTH-1:0]  sram_waddr,
    output logic [SRAM_DATA_WIDTH-1:0]  sram_wdata,
    output logic [NUM_SRAM_BANKS-1:0]   sram_we
`ifdef AXI_INTERCONNECT_IRQ_EN
    ,
    output logic                        irq
`endif
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] VERSION     = 32'h0002_0000 | 32'(NUM_LANES);

    logic                       aw_held_reg, w_held_reg, bvalid_reg, rvalid_reg;
    logic [ADDR_WIDTH-1:0]      awaddr_reg;
    logic [31:0]                wdata_reg, rdata_reg;
    logic [1:0]                 bresp_reg, rresp_reg;
    logic [ADDR_WIDTH-1:0]      base_addr_reg;
    logic [15:0]                depth_reg, lane_count_reg;
    logic [7:0]                 stride_reg;
    logic [31:0]                hints_reg;
    logic                       busy_reg, done_sticky_reg, start_reg, irq_enable_reg;
    logic [NUM_SRAM_BANKS-1:0]  sram_we_reg, sram_we_next;
    logic [SRAM_ADDR_WIDTH-1:0] sram_waddr_reg;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata_reg;

    // Write decode results (driven from the held AW/W registers)
    logic       wr_commit, wr_err, wr_start, wr_w1c, wr_base, wr_depth, wr_stride;
    logic       wr_hints, wr_lanes, wr_irq, wr_sram;
    logic [3:0] wr_win, wr_bank;
    logic [9:0] wr_word;
    // Read decode results (driven from the live AR channel)
    logic [3:0]  rd_win;
    logic [9:0]  rd_word;
    logic [31:0] rd_data;
    logic        rd_err;
    logic [31:0] lane_word [64];
    logic        unused_addr_bits;

    assign s_axi_awready     = !aw_held_reg && !bvalid_reg;
    assign s_axi_wready      = !w_held_reg && !bvalid_reg;
    assign s_axi_arready     = !rvalid_reg;
    assign s_axi_bvalid      = bvalid_reg;
    assign s_axi_bresp       = bresp_reg;
    assign s_axi_rvalid      = rvalid_reg;
    assign s_axi_rresp       = rresp_reg;
    assign s_axi_rdata       = rdata_reg;
    assign fabric_base_addr  = base_addr_reg;
    assign fabric_depth      = depth_reg;
    assign fabric_stride     = stride_reg;
    assign fabric_exec_hints = hints_reg;
    assign fabric_lane_count = lane_count_reg;
    assign fabric_start      = start_reg;
    assign sram_waddr        = sram_waddr_reg;
    assign sram_wdata        = sram_wdata_reg;
    assign sram_we           = sram_we_reg;
`ifdef AXI_INTERCONNECT_IRQ_EN
    assign irq = done_sticky_reg & irq_enable_reg;
`endif
    assign unused_addr_bits = ^{s_axi_araddr, awaddr_reg};

    assign wr_commit = aw_held_reg && w_held_reg;
    assign wr_win    = awaddr_reg[15:12];
    assign wr_word   = awaddr_reg[11:2];
    assign wr_bank   = wr_win - 4'd1;
    assign rd_win    = s_axi_araddr[15:12];
    assign rd_word   = s_axi_araddr[11:2];

    // Lane results padded to 64 entries so a 6-bit index never runs off the end
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_lane
            if (gi < NUM_LANES) begin : g_on
                assign lane_word[gi] = vector_results[gi*32 +: 32];
            end else begin : g_off
                assign lane_word[gi] = 32'd0;
            end
        end
        for (gi = 0; gi < NUM_SRAM_BANKS; gi++) begin : g_we
            assign sram_we_next[gi] = wr_commit && wr_sram && (wr_bank == 4'(gi));
        end
    endgenerate

    // Classify the held write: which target it hits and whether it is rejected
    always_comb begin
        wr_err = 1'b1;  wr_start = 1'b0; wr_w1c = 1'b0; wr_base = 1'b0;
        wr_depth = 1'b0; wr_stride = 1'b0; wr_hints = 1'b0; wr_lanes = 1'b0;
        wr_irq = 1'b0;  wr_sram = 1'b0;
        if (wr_win == 4'd0) begin
            case (wr_word)
                10'h000: begin wr_err = wdata_reg[0] && busy_reg; wr_start = wdata_reg[0] && !busy_reg; end
                10'h001: begin wr_err = 1'b0; wr_w1c = wdata_reg[1]; end
                10'h002: begin wr_err = busy_reg; wr_base   = !busy_reg; end
                10'h003: begin wr_err = busy_reg; wr_depth  = !busy_reg; end
                10'h004: begin wr_err = busy_reg; wr_stride = !busy_reg; end
                10'h005: begin wr_err = busy_reg; wr_hints  = !busy_reg; end
                10'h006: begin wr_err = busy_reg; wr_lanes  = !busy_reg; end
`ifdef AXI_INTERCONNECT_IRQ_EN
                10'h008: begin wr_err = 1'b0; wr_irq = 1'b1; end
`endif
                default: wr_err = 1'b1;
            endcase
        end else if ({28'd0, wr_bank} < NUM_SRAM_BANKS) begin
            wr_err  = 1'b0;
            wr_sram = 1'b1;
        end
    end

    // Read mux; errors return the DEADBEEF marker
    always_comb begin
        rd_data = 32'd0;
        rd_err  = 1'b1;
        if (rd_win == 4'd0) begin
            rd_err = 1'b0;
            case (rd_word)
                10'h000: rd_data = 32'd0;
                10'h001: rd_data = {30'd0, done_sticky_reg, busy_reg};
                10'h002: rd_data = 32'(base_addr_reg);
                10'h003: rd_data = {16'd0, depth_reg};
                10'h004: rd_data = {24'd0, stride_reg};
                10'h005: rd_data = hints_reg;
                10'h006: rd_data = {16'd0, lane_count_reg};
                10'h007: rd_data = VERSION;
`ifdef AXI_INTERCONNECT_IRQ_EN
                10'h008: rd_data = {31'd0, irq_enable_reg};
`endif
                default: begin
                    if (rd_word[9:6] == 4'b0001 && {26'd0, rd_word[5:0]} < NUM_LANES)
                        rd_data = lane_word[rd_word[5:0]];
                    else
                        rd_err = 1'b1;
                end
            endcase
        end
        if (rd_err) rd_data = 32'hDEAD_BEEF;
    end

    // AW/W holding registers and the write response
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            aw_held_reg <= 1'b0; w_held_reg <= 1'b0;
            awaddr_reg  <= '0;   wdata_reg  <= '0;
            bvalid_reg  <= 1'b0; bresp_reg  <= RESP_OKAY;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held_reg <= 1'b1;
                awaddr_reg  <= s_axi_awaddr;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= s_axi_wdata;
            end
            if (wr_commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_reg && s_axi_bready) begin
                bvalid_reg  <= 1'b0;
            end
        end
    end

    // Config registers and SRAM port, updated only by accepted writes
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            base_addr_reg <= '0; depth_reg <= '0; stride_reg <= '0; hints_reg <= '0;
            lane_count_reg <= 16'(NUM_LANES);
            irq_enable_reg <= 1'b0;
            sram_we_reg <= '0; sram_waddr_reg <= '0; sram_wdata_reg <= '0;
        end else begin
            sram_we_reg <= sram_we_next;
            if (wr_commit) begin
                if (wr_base)   base_addr_reg <= ADDR_WIDTH'(wdata_reg);
                if (wr_depth)  depth_reg     <= wdata_reg[15:0];
                if (wr_stride) stride_reg    <= wdata_reg[7:0];
                if (wr_hints)  hints_reg     <= wdata_reg;
                if (wr_lanes)  lane_count_reg <= (wdata_reg == 32'd0 || wdata_reg > 32'(NUM_LANES))
                                                 ? 16'(NUM_LANES) : wdata_reg[15:0];
                if (wr_irq)    irq_enable_reg <= wdata_reg[0];
                if (wr_sram) begin
                    sram_waddr_reg <= awaddr_reg[SRAM_ADDR_WIDTH+1:2];
                    sram_wdata_reg <= wdata_reg[SRAM_DATA_WIDTH-1:0];
                end
            end
        end
    end

    // Start/busy/done control; done overrides a same-cycle W1C
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            busy_reg <= 1'b0; done_sticky_reg <= 1'b0; start_reg <= 1'b0;
        end else begin
            start_reg <= wr_commit && wr_start;
            if (wr_commit && wr_start) begin
                busy_reg        <= 1'b1;
                done_sticky_reg <= 1'b0;
            end else if (wr_commit && wr_w1c) begin
                done_sticky_reg <= 1'b0;
            end
            if (fabric_done && busy_reg) begin
                busy_reg        <= 1'b0;
                done_sticky_reg <= 1'b1;
            end
        end
    end

    // Read channel: capture on AR handshake, hold until rready
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            rvalid_reg <= 1'b0; rdata_reg <= '0; rresp_reg <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data;
            rresp_reg  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_reg && s_axi_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule
